intr_priority_ctrl: RTL and testbench
=====================================

INTR_PRIORITY_CTRL -- requirements
Module: intr_priority_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 8, number of interrupt channels (legal 2..16).
REQ-002 SHALL have parameter ADDR_W, default `IM_ADDR_BIT, width of the vector address.
REQ-003 SHALL have parameter VEC_BASE, default `INTERRUPT_VECTOR_TOP_DIV4, vector address of channel 0.
REQ-004 SHALL have parameter VEC_STRIDE, default 4, address step between channel vectors.
REQ-005 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port intr_en, input, 1, global interrupt enable.
REQ-008 SHALL have port intr_mask, input, NCH, per-channel enable (1 = enabled).
REQ-009 SHALL have port device_request, input, NCH, synchronous level requests from devices.
REQ-010 SHALL have port intr_ack, input, 1, core accepted the pending jump this cycle.
REQ-011 SHALL have port eret_clear_en, input, 1, return-from-interrupt strobe.
REQ-012 SHALL have port intr_jmp, output, 1, jump request to the core (registered).
REQ-013 SHALL have port intr_jmp_addr, output, ADDR_W, vector address of intr_id.
REQ-014 SHALL have port intr_id, output, clog2(NCH), channel being requested.
REQ-015 SHALL have ports pending and in_service, output, NCH each, status registers.

Function
REQ-016 SHALL register device_request into req_q each cycle; rise = device_request & ~req_q.
REQ-017 SHALL set pending[i] on rise[i]; a request held high sets pending once only.
REQ-018 SHALL define candidate = highest index i with pending[i] & intr_mask[i]; none if zero.
REQ-019 SHALL define level = highest set index of in_service, or -1 when in_service is zero.
REQ-020 SHALL implement FSM states IDLE and REQ; intr_jmp = 1 exactly in REQ.
REQ-021 IDLE -> REQ when intr_en & candidate valid & candidate > level; intr_id latched to candidate on the same edge.
REQ-022 In REQ with intr_ack: pending[intr_id] cleared, in_service[intr_id] set, -> IDLE.
REQ-023 In REQ with no intr_ack and (!intr_en or !intr_mask[intr_id]): withdraw -> IDLE; pending kept.
REQ-024 In REQ, intr_id SHALL NOT change even if a higher candidate appears; re-arbitration happens after returning to IDLE.
REQ-025 Latency: rise sampled at edge t -> pending at t+1 -> intr_jmp high after edge t+2.
REQ-026 intr_jmp_addr = VEC_BASE + intr_id*VEC_STRIDE, truncated to ADDR_W bits, combinational from intr_id.
REQ-027 eret_clear_en SHALL clear in_service[level], evaluated on the pre-edge value; ignored when in_service is zero.
REQ-028 eret_clear_en and intr_ack in the same cycle SHALL both take effect; they target distinct bits because intr_id > level.
REQ-029 A rise on channel intr_id in the same cycle as intr_ack SHALL leave pending[intr_id] = 1 (set wins).
REQ-030 intr_ack outside REQ SHALL be ignored.

Reset
REQ-031 On rst_n low, asynchronously: state IDLE, intr_jmp 0, intr_id 0 (intr_jmp_addr = VEC_BASE), pending 0, in_service 0, req_q 0.
REQ-032 Reset mid-REQ SHALL discard the request; no channel is left in service.

Verification (NCH=8, VEC_BASE=0x100, VEC_STRIDE=4)
REQ-033 SHALL check intr_en=1, mask=0xFF, rise on req[2] -> intr_jmp after 2 edges, addr 0x108; ack -> in_service=0x04, pending=0x00.
REQ-034 SHALL check simultaneous rise on req[1] and req[5] -> id 5, addr 0x114; after ack, ch1 not taken; eret -> in_service=0, then id 1, addr 0x104.
REQ-035 SHALL check nesting: ch2 in service, rise req[6] -> preempt, in_service=0x44; eret -> 0x04; a later rise on req[1] is held until the next eret.
REQ-036 SHALL check req[3] held high 10 cycles with mask[3]=0 -> pending=0x08, no intr_jmp; mask[3]=1 -> intr_jmp, addr 0x10C; only one jump total.
REQ-037 SHALL check withdraw: in REQ, intr_en drops -> intr_jmp 0 next cycle, pending bit kept; re-enable -> same id re-requested.
REQ-038 SHALL check rst_n asserted while intr_jmp=1 -> all outputs at reset values immediately; no jump after rst_n releases.

Source files
------------

// File: rtl/intr_priority_ctrl_if.sv
// Bundles the interrupt controller's core-side and device-side signals.
// The slave modport is the controller. The master modport is whatever drives
// the requests and consumes the jump.
interface intr_priority_ctrl_if #(
  parameter int NCH    = 8,
  parameter int ADDR_W = 16
);
  localparam int ID_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic              intr_en;
  logic [NCH-1:0]    intr_mask;
  logic [NCH-1:0]    device_request;
  logic              intr_ack;
  logic              eret_clear_en;
  logic              intr_jmp;
  logic [ADDR_W-1:0] intr_jmp_addr;
  logic [ID_W-1:0]   intr_id;
  logic [NCH-1:0]    pending;
  logic [NCH-1:0]    in_service;

  modport master (
    output intr_en, intr_mask, device_request, intr_ack, eret_clear_en,
    input  intr_jmp, intr_jmp_addr, intr_id, pending, in_service
  );

  modport slave (
    input  intr_en, intr_mask, device_request, intr_ack, eret_clear_en,
    output intr_jmp, intr_jmp_addr, intr_id, pending, in_service
  );
endinterface

// File: rtl/intr_priority_ctrl.sv
// Priority interrupt controller with nesting.
// Rising edges on device requests latch into pending. The highest-numbered
// enabled pending channel preempts the current service level. The selected
// channel is presented to the core as a registered jump request together with
// its vector address.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 16
`endif
`ifndef INTERRUPT_VECTOR_TOP_DIV4
`define INTERRUPT_VECTOR_TOP_DIV4 256
`endif

module intr_priority_ctrl #(
  parameter int NCH        = 8,
  parameter int ADDR_W     = `IM_ADDR_BIT,
  parameter int VEC_BASE   = `INTERRUPT_VECTOR_TOP_DIV4,
  parameter int VEC_STRIDE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  intr_priority_ctrl_if.slave bus
);
  localparam int ID_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state, state_next;
  logic [NCH-1:0]  req_q;
  logic [NCH-1:0]  rise;
  logic [NCH-1:0]  eligible;
  logic [NCH-1:0]  pending, pending_next;
  logic [NCH-1:0]  in_service, in_service_next;
  logic [ID_W-1:0] intr_id, intr_id_next;
  logic [ID_W-1:0] cand_id, level_id;
  logic            cand_valid, level_valid;
  logic            take, ack_take, eret_take;

  assign rise     = bus.device_request & ~req_q;
  assign eligible = pending & bus.intr_mask;

  // Highest-numbered enabled pending channel is the arbitration winner.
  always_comb begin
    cand_id    = '0;
    cand_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (eligible[i]) begin
        cand_id    = ID_W'(i);
        cand_valid = 1'b1;
      end
    end
  end

  // Current nesting level is the highest channel still in service.
  always_comb begin
    level_id    = '0;
    level_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (in_service[i]) begin
        level_id    = ID_W'(i);
        level_valid = 1'b1;
      end
    end
  end

  assign take      = bus.intr_en & cand_valid & (~level_valid | (cand_id > level_id));
  assign eret_take = bus.eret_clear_en & level_valid;

  // Next-state logic: the channel is frozen while requesting. Withdraw the
  // request if interrupts are globally disabled or that channel gets masked.
  always_comb begin
    state_next   = state;
    intr_id_next = intr_id;
    ack_take     = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          state_next   = REQ;
          intr_id_next = cand_id;
        end
      end
      REQ: begin
        if (bus.intr_ack) begin
          ack_take   = 1'b1;
          state_next = IDLE;
        end else if (!bus.intr_en || !bus.intr_mask[intr_id]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending and in-service updates. A new rise wins over an acknowledge on
  // the same bit. Return-from-interrupt clears the pre-edge level.
  always_comb begin
    pending_next    = pending;
    in_service_next = in_service;
    if (ack_take) begin
      pending_next[intr_id]    = 1'b0;
      in_service_next[intr_id] = 1'b1;
    end
    if (eret_take) begin
      in_service_next[level_id] = 1'b0;
    end
    pending_next = pending_next | rise;
  end

  // State and status registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      intr_id    <= '0;
      req_q      <= '0;
      pending    <= '0;
      in_service <= '0;
    end else begin
      state      <= state_next;
      intr_id    <= intr_id_next;
      req_q      <= bus.device_request;
      pending    <= pending_next;
      in_service <= in_service_next;
    end
  end

  assign bus.intr_jmp      = (state == REQ);
  assign bus.intr_id       = intr_id;
  assign bus.intr_jmp_addr = ADDR_W'(VEC_BASE) + ADDR_W'(intr_id) * ADDR_W'(VEC_STRIDE);
  assign bus.pending       = pending;
  assign bus.in_service    = in_service;
endmodule

// File: tb/tb_intr_priority_ctrl.sv
// Directed bench for intr_priority_ctrl with NCH=8, VEC_BASE=0x100, stride 4.
module tb_intr_priority_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   jumps;

  intr_priority_ctrl_if #(.NCH(8), .ADDR_W(12)) bus ();

  intr_priority_ctrl #(
    .NCH(8), .ADDR_W(12), .VEC_BASE(12'h100), .VEC_STRIDE(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic en, input logic [7:0] mask,
                               input logic [7:0] req, input logic ack,
                               input logic eret);
    bus.intr_en        = en;
    bus.intr_mask      = mask;
    bus.device_request = req;
    bus.intr_ack       = ack;
    bus.eret_clear_en  = eret;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    jumps = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #3;
    checkOutput("rst_jmp", 32'(bus.intr_jmp), 32'h0);
    checkOutput("rst_addr", 32'(bus.intr_jmp_addr), 32'h100);
    checkOutput("rst_id", 32'(bus.intr_id), 32'h0);
    checkOutput("rst_pend", 32'(bus.pending), 32'h0);
    checkOutput("rst_insv", 32'(bus.in_service), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single request on channel 2.
    applyStimulus(1'b1, 8'hFF, 8'h04, 1'b0, 1'b0);
    tick();
    checkOutput("c2_pend", 32'(bus.pending), 32'h04);
    checkOutput("c2_nojmp_yet", 32'(bus.intr_jmp), 32'h0);
    tick();
    checkOutput("c2_jmp", 32'(bus.intr_jmp), 32'h1);
    checkOutput("c2_addr", 32'(bus.intr_jmp_addr), 32'h108);
    applyStimulus(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
    checkOutput("c2_insv", 32'(bus.in_service), 32'h04);
    checkOutput("c2_pend_clr", 32'(bus.pending), 32'h00);
    checkOutput("c2_jmp_off", 32'(bus.intr_jmp), 32'h0);
    applyStimulus(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
    checkOutput("c2_eret", 32'(bus.in_service), 32'h00);

    // Simultaneous channels 1 and 5.
    applyStimulus(1'b1, 8'hFF, 8'h22, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("c15_id", 32'(bus.intr_id), 32'h5);
    checkOutput("c15_addr", 32'(bus.intr_jmp_addr), 32'h114);
    applyStimulus(1'b1, 8'hFF, 8'h22, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h22, 1'b0, 1'b0);
    tick();
    checkOutput("c15_ch1_held", 32'(bus.intr_jmp), 32'h0);
    checkOutput("c15_pend", 32'(bus.pending), 32'h02);
    checkOutput("c15_insv", 32'(bus.in_service), 32'h20);
    applyStimulus(1'b1, 8'hFF, 8'h22, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h22, 1'b0, 1'b0);
    checkOutput("c15_eret", 32'(bus.in_service), 32'h00);
    tick();
    checkOutput("c15_jmp1", 32'(bus.intr_jmp), 32'h1);
    checkOutput("c15_addr1", 32'(bus.intr_jmp_addr), 32'h104);
    applyStimulus(1'b1, 8'hFF, 8'h22, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h22, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("c15_clean", 32'(bus.in_service), 32'h00);

    // Nesting: channel 6 preempts channel 2, channel 1 waits.
    applyStimulus(1'b1, 8'hFF, 8'h04, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h04, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h44, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("nest_id6", 32'(bus.intr_id), 32'h6);
    checkOutput("nest_jmp6", 32'(bus.intr_jmp), 32'h1);
    applyStimulus(1'b1, 8'hFF, 8'h44, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h44, 1'b0, 1'b0);
    checkOutput("nest_insv44", 32'(bus.in_service), 32'h44);
    applyStimulus(1'b1, 8'hFF, 8'h44, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h46, 1'b0, 1'b0);
    checkOutput("nest_insv04", 32'(bus.in_service), 32'h04);
    tick();
    tick();
    tick();
    checkOutput("nest_ch1_held", 32'(bus.intr_jmp), 32'h0);
    checkOutput("nest_ch1_pend", 32'(bus.pending), 32'h02);
    applyStimulus(1'b1, 8'hFF, 8'h46, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h46, 1'b0, 1'b0);
    checkOutput("nest_eret2", 32'(bus.in_service), 32'h00);
    tick();
    checkOutput("nest_jmp1", 32'(bus.intr_jmp), 32'h1);
    checkOutput("nest_id1", 32'(bus.intr_id), 32'h1);
    applyStimulus(1'b1, 8'hFF, 8'h46, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h46, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
    tick();

    // Channel 3 held high while masked, then unmasked: exactly one jump.
    applyStimulus(1'b1, 8'hF7, 8'h08, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      jumps += int'(bus.intr_jmp);
    end
    checkOutput("mask_pend", 32'(bus.pending), 32'h08);
    checkOutput("mask_nojmp", 32'(jumps), 32'h0);
    applyStimulus(1'b1, 8'hFF, 8'h08, 1'b0, 1'b0);
    tick();
    jumps += int'(bus.intr_jmp);
    checkOutput("mask_jmp", 32'(bus.intr_jmp), 32'h1);
    checkOutput("mask_addr", 32'(bus.intr_jmp_addr), 32'h10C);
    applyStimulus(1'b1, 8'hFF, 8'h08, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h08, 1'b0, 1'b0);
    jumps += int'(bus.intr_jmp);
    for (int i = 0; i < 5; i++) begin
      tick();
      jumps += int'(bus.intr_jmp);
    end
    checkOutput("mask_one_jump", 32'(jumps), 32'h1);
    checkOutput("mask_insv", 32'(bus.in_service), 32'h08);
    applyStimulus(1'b1, 8'hFF, 8'h08, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
    tick();

    // Withdraw on global disable, then re-request the same channel.
    applyStimulus(1'b1, 8'hFF, 8'h10, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("wd_jmp", 32'(bus.intr_jmp), 32'h1);
    applyStimulus(1'b0, 8'hFF, 8'h10, 1'b0, 1'b0);
    tick();
    checkOutput("wd_off", 32'(bus.intr_jmp), 32'h0);
    checkOutput("wd_pend", 32'(bus.pending), 32'h10);
    tick();
    checkOutput("wd_still_off", 32'(bus.intr_jmp), 32'h0);
    applyStimulus(1'b1, 8'hFF, 8'h10, 1'b0, 1'b0);
    tick();
    checkOutput("wd_rejmp", 32'(bus.intr_jmp), 32'h1);
    checkOutput("wd_id", 32'(bus.intr_id), 32'h4);
    applyStimulus(1'b1, 8'hFF, 8'h10, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h10, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
    tick();

    // Reset while a jump is being requested.
    applyStimulus(1'b1, 8'hFF, 8'h80, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rr_jmp", 32'(bus.intr_jmp), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rr_jmp0", 32'(bus.intr_jmp), 32'h0);
    checkOutput("rr_addr", 32'(bus.intr_jmp_addr), 32'h100);
    checkOutput("rr_pend", 32'(bus.pending), 32'h0);
    checkOutput("rr_insv", 32'(bus.in_service), 32'h0);
    applyStimulus(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    jumps = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      jumps += int'(bus.intr_jmp);
    end
    checkOutput("rr_nojmp", 32'(jumps), 32'h0);
    checkOutput("rr_pend_after", 32'(bus.pending), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
